// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory access controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   logic found;
   int   j;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (en && !found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Round-robin multi-port front end for a single-ported synchronous memory.
// One transaction in flight: IDLE -> ACCESS (LAT strobe cycles) -> RESP.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int NUM_PORTS = 2,
   parameter int RD_LAT    = 2,
   parameter int WR_LAT    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          req_valid,
   input  logic [NUM_PORTS-1:0]          req_we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
   output logic [NUM_PORTS-1:0]          req_ready,
   output logic [NUM_PORTS-1:0]          rsp_valid,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic                          rsp_err,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          mem_rd_en,
   output logic                          mem_wr_en
);

   localparam int OFF    = clog2(DATA_W / 8);
   localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CW     = clog2(MAXLAT + 1);
   localparam int PW     = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

   state_e                state_q;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]         cnt_q, last_cnt;
   logic                  we_q;
   logic [NUM_PORTS-1:0]  port_oh_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic [DATA_W-1:0]     mem_wdata_q, rsp_rdata_q;
   logic                  rd_en_q, wr_en_q, rsp_err_q;
   logic [NUM_PORTS-1:0]  rsp_valid_q;

   logic [NUM_PORTS-1:0]  grant;
   logic [PW-1:0]         grant_idx;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic                  sel_we, accept, misaligned, idle;

   assign idle = (state_q == ST_IDLE);

   rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .en        (idle),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grant is one-hot, so an OR-mux picks the winner's request fields.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[p*DATA_W +: DATA_W];
            sel_we    = req_we[p];
         end
      end
   end

   assign accept     = |(req_valid & grant);
   assign misaligned = (sel_addr & OFF_MASK) != '0;
   assign last_cnt   = we_q ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
   assign rr_ptr_d   = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         port_oh_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  port_oh_q   <= grant;
                  we_q        <= sel_we;
                  mem_addr_q  <= sel_addr >> OFF;
                  mem_wdata_q <= sel_wdata;
                  rr_ptr_q    <= rr_ptr_d;
                  cnt_q       <= '0;
                  if (misaligned) begin
                     rsp_valid_q <= grant;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     state_q     <= ST_RESP;
                  end else begin
                     rd_en_q <= ~sel_we;
                     wr_en_q <= sel_we;
                     state_q <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt_q == last_cnt) begin
                  rd_en_q     <= 1'b0;
                  wr_en_q     <= 1'b0;
                  rsp_rdata_q <= we_q ? '0 : mem_rdata;
                  rsp_valid_q <= port_oh_q;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               rsp_valid_q <= '0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd_en = rd_en_q;
   assign mem_wr_en = wr_en_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: vector table on the default build, corner sequences, and a
// 64-bit / 3-port / RD_LAT=4 instance.
module tb_mem_access_ctrl;

   logic clk, reset;

   // default-parameter instance
   logic [1:0]  a_req_valid, a_req_we, a_req_ready, a_rsp_valid;
   logic [63:0] a_req_addr, a_req_wdata;
   logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_rsp_err, a_mem_rd_en, a_mem_wr_en;

   // DATA_W=64, NUM_PORTS=3, RD_LAT=4 instance
   logic [2:0]   b_req_valid, b_req_we, b_req_ready, b_rsp_valid;
   logic [95:0]  b_req_addr;
   logic [191:0] b_req_wdata;
   logic [63:0]  b_rsp_rdata, b_mem_wdata, b_mem_rdata;
   logic [31:0]  b_mem_addr;
   logic         b_rsp_err, b_mem_rd_en, b_mem_wr_en;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_ctrl dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr),
      .req_wdata(a_req_wdata), .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .mem_rd_en(a_mem_rd_en), .mem_wr_en(a_mem_wr_en)
   );

   mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .NUM_PORTS(3), .RD_LAT(4), .WR_LAT(2)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_maddr;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Single-port transaction on dut_a, launched at a negedge.
   task automatic a_txn(input vec_t v);
      int          strobes, rsp_cyc;
      logic        addr_ok, wdata_ok, wrong_strobe, er;
      logic [1:0]  exp_oh, rv;
      logic [31:0] rd;
      exp_oh = 2'b01 << v.port;
      a_req_addr = '0;
      a_req_wdata = '0;
      a_req_we = '0;
      a_req_addr[v.port*32 +: 32]  = v.addr;
      a_req_wdata[v.port*32 +: 32] = v.wdata;
      a_req_we[v.port] = v.we;
      a_req_valid = exp_oh;
      a_mem_rdata = v.rdata;
      #1;
      chk("ready", a_req_ready, exp_oh);
      strobes = 0; rsp_cyc = -1; addr_ok = 1; wdata_ok = 1; wrong_strobe = 0;
      rv = '0; rd = '0; er = 0;
      for (int c = 1; c <= 12 && rsp_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) a_req_valid = '0;
         if (a_mem_rd_en || a_mem_wr_en) begin
            strobes++;
            if (a_mem_addr !== v.exp_maddr) addr_ok = 0;
            if (v.we && a_mem_wdata !== v.wdata) wdata_ok = 0;
            if (v.we ? a_mem_rd_en : a_mem_wr_en) wrong_strobe = 1;
         end
         if (a_rsp_valid != 0) begin
            rsp_cyc = c; rv = a_rsp_valid; rd = a_rsp_rdata; er = a_rsp_err;
         end
      end
      chk("rsp_cycle", rsp_cyc, v.exp_lat + 1);
      chk("strobe_cycles", strobes, v.exp_lat);
      chk("rsp_valid", rv, exp_oh);
      chk("rsp_err", er, v.exp_err);
      chk("rsp_rdata", rd, v.exp_rdata);
      chk("mem_addr_ok", addr_ok, 1);
      chk("mem_wdata_ok", wdata_ok, 1);
      chk("strobe_kind", wrong_strobe, 0);
      @(negedge clk);
      chk("rsp_single_cycle", a_rsp_valid, 2'b00);
   endtask

   initial begin
      int   gcount, gports[4], gcyc[4];
      logic prev_rdy, dbl, busy, seen_rsp, addr_ok;
      int   strobes, rsp_cyc;
      logic [2:0]  rv;
      logic [63:0] rd;
      logic        er;

      vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'h4,         32'hDEAD_BEEF, 2, 1'b0};
      vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_2222, 32'h8,         32'h0,         2, 1'b0};
      vecs[2] = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'h5555_AAAA, 32'h0,         32'h0,         0, 1'b1};
      vecs[3] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 32'h3FFF_FFFF, 32'h1234_5678, 2, 1'b0};
      vecs[4] = '{0, 1'b1, 32'h0000_0002, 32'hAAAA_0001, 32'h0,         32'h0,         32'h0,         0, 1'b1};
      vecs[5] = '{1, 1'b0, 32'h0000_0011, 32'h0,         32'h7777_7777, 32'h0,         32'h0,         0, 1'b1};

      reset = 1;
      a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0; a_mem_rdata = '0;
      b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0; b_mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", a_req_ready, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_rsp_err", a_rsp_err, 0);
      chk("rst_strobes", {a_mem_rd_en, a_mem_wr_en}, 0);
      chk("rst_rsp_rdata", a_rsp_rdata, 0);
      chk("rst_mem_addr_wdata", {a_mem_addr, a_mem_wdata}, 0);
      chk("rst_b_outputs", {b_rsp_valid, b_mem_rd_en, b_mem_wr_en, b_mem_addr}, 0);
      reset = 0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) a_txn(vecs[i]);

      // contention: both ports hold requests; grants must alternate
      reset = 1;
      @(negedge clk);
      reset = 0;
      a_req_addr = {32'h0000_0200, 32'h0000_0100};
      a_req_we = '0;
      a_mem_rdata = 32'h0BAD_F00D;
      a_req_valid = 2'b11;
      gcount = 0; prev_rdy = 0; dbl = 0; busy = 0;
      for (int c = 0; c < 40 && gcount < 4; c++) begin
         #1;
         if (a_req_ready != 0) begin
            if (prev_rdy) dbl = 1;
            if (a_mem_rd_en || a_mem_wr_en || a_rsp_valid != 0) busy = 1;
            gports[gcount] = (a_req_ready == 2'b10) ? 1 : (a_req_ready == 2'b01) ? 0 : 9;
            gcyc[gcount] = c;
            gcount++;
            prev_rdy = 1;
         end else prev_rdy = 0;
         @(negedge clk);
      end
      a_req_valid = '0;
      chk("cont_grants", gcount, 4);
      chk("cont_order", {gports[0][3:0], gports[1][3:0], gports[2][3:0], gports[3][3:0]}, 16'h0101);
      chk("cont_spacing", {gcyc[1]-gcyc[0], gcyc[2]-gcyc[1], gcyc[3]-gcyc[2]}, {32'd4, 32'd4, 32'd4});
      chk("cont_ready_one_cycle", dbl, 0);
      chk("cont_ready_idle_only", busy, 0);
      repeat (4) @(negedge clk);

      // reset abort during the second ACCESS cycle of a read
      a_req_addr = {32'h0, 32'h0000_0010};
      a_mem_rdata = 32'hFEED_FACE;
      a_req_valid = 2'b01;
      @(negedge clk);
      a_req_valid = '0;
      chk("abort_rd_c1", a_mem_rd_en, 1);
      @(negedge clk);
      chk("abort_rd_c2", a_mem_rd_en, 1);
      reset = 1;
      @(negedge clk);
      chk("abort_strobe_low", {a_mem_rd_en, a_mem_wr_en}, 0);
      chk("abort_no_rsp", a_rsp_valid, 0);
      chk("abort_rr_ptr", dut_a.rr_ptr_q, 0);
      reset = 0;
      seen_rsp = 0;
      repeat (4) begin
         @(negedge clk);
         if (a_rsp_valid != 0 || a_mem_rd_en) seen_rsp = 1;
      end
      chk("abort_quiet", seen_rsp, 0);
      a_txn('{1, 1'b0, 32'h0000_0104, 32'h0, 32'h600D_0001, 32'h41, 32'h600D_0001, 2, 1'b0});

      // wide instance: port 2 aligned read, RD_LAT=4
      b_req_addr = '0;
      b_req_addr[64 +: 32] = 32'h0000_0040;
      b_mem_rdata = 64'h0123_4567_89AB_CDEF;
      b_req_valid = 3'b100;
      #1;
      chk("b_ready", b_req_ready, 3'b100);
      strobes = 0; rsp_cyc = -1; addr_ok = 1; rv = '0; rd = '0; er = 0;
      for (int c = 1; c <= 12 && rsp_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) b_req_valid = '0;
         if (b_mem_rd_en) begin
            strobes++;
            if (b_mem_addr !== 32'h8) addr_ok = 0;
         end
         if (b_rsp_valid != 0) begin
            rsp_cyc = c; rv = b_rsp_valid; rd = b_rsp_rdata; er = b_rsp_err;
         end
      end
      chk("b_rsp_cycle", rsp_cyc, 5);
      chk("b_strobes", strobes, 4);
      chk("b_mem_addr", addr_ok, 1);
      chk("b_rsp_valid", rv, 3'b100);
      chk("b_rdata", rd, 64'h0123_4567_89AB_CDEF);
      chk("b_err", er, 0);
      @(negedge clk);

      // wide instance: 0x44 is not 8-byte aligned
      b_req_addr = '0;
      b_req_addr[32 +: 32] = 32'h0000_0044;
      b_req_valid = 3'b010;
      #1;
      chk("b_mis_ready", b_req_ready, 3'b010);
      strobes = 0; rsp_cyc = -1; rv = '0; rd = '1; er = 0;
      for (int c = 1; c <= 8 && rsp_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) b_req_valid = '0;
         if (b_mem_rd_en || b_mem_wr_en) strobes++;
         if (b_rsp_valid != 0) begin
            rsp_cyc = c; rv = b_rsp_valid; rd = b_rsp_rdata; er = b_rsp_err;
         end
      end
      chk("b_mis_rsp_cycle", rsp_cyc, 1);
      chk("b_mis_strobes", strobes, 0);
      chk("b_mis_rsp_valid", rv, 3'b010);
      chk("b_mis_err", er, 1);
      chk("b_mis_rdata", rd, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-port memory access controller sitting between the processor's requesters (fetch, load/store, etc.) and a single-ported synchronous memory. Arbitrates round-robin among `NUM_PORTS` requesters and converts byte addresses to word addresses. Drives read or write strobes for a configurable number of wait cycles and returns a one-cycle response with read data or a misalignment error. Uses separate read and write data buses; there are no tri-states.

## Interface
- `DATA_W`, 32: data width, bits; multiple of 8, power of two.
- `ADDR_W`, 32: byte-address width.
- `NUM_PORTS`, 2: requester count, 1..8.
- `RD_LAT`, 2: cycles `mem_rd_en` is held, ≥1.
- `WR_LAT`, 2: cycles `mem_wr_en` is held, ≥1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_PORTS  per-port request.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*ADDR_W  byte addresses; port p at `[p*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_PORTS*DATA_W  write data; packed the same way.
- `req_ready`  out  NUM_PORTS  one-hot grant/accept.
- `rsp_valid`  out  NUM_PORTS  one-hot, single-cycle response.
- `rsp_rdata`  out  DATA_W  read data, shared by all ports.
- `rsp_err`  out  1  misaligned request, qualified by `rsp_valid`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_rdata`  in  DATA_W  read data from memory.
- `mem_rd_en`  out  1  read strobe.
- `mem_wr_en`  out  1  write strobe.

## Operation
- Define `OFF = log2(DATA_W/8)`.
- Word address: `mem_addr = {OFF zeros, addr[ADDR_W-1:OFF]}`.
- A request is misaligned when `addr[OFF-1:0] != 0`.
- FSM states:
  - **IDLE**: the arbiter picks the first valid port at or after `rr_ptr`, wrapping. `req_ready[g]` is asserted combinationally, IDLE only. On handshake (`req_valid[g] & req_ready[g]` at the edge), latch port, we, addr, wdata and set `rr_ptr <= (g+1) mod NUM_PORTS`.
    - Aligned request -> ACCESS.
    - Misaligned request -> RESP with err=1; no memory strobe.
    - No valid port -> stay in IDLE; `rr_ptr` unchanged.
  - **ACCESS**: `mem_rd_en` (read) or `mem_wr_en` (write) held high; counter runs 0..LAT-1. `mem_addr`/`mem_wdata` are stable from the latched values. At the edge ending the last ACCESS cycle, a read captures `mem_rdata` into the response register. -> RESP.
  - **RESP**: `rsp_valid[port]`=1 for exactly one cycle.
    - `rsp_rdata` = captured data for reads, 0 for writes and errors.
    - `rsp_err` as latched.
    - -> IDLE.
- Only one transaction is in flight. Requesters hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until accepted; a requester that drops valid before acceptance loses its turn silently.
- Responses have no backpressure; the requester must sample `rsp_valid`.

## Timing
- Reset values: `req_ready`, `rsp_valid`, `rsp_err`, `mem_rd_en`, `mem_wr_en`, `rsp_rdata`, `mem_addr` and `mem_wdata` are all 0. State = IDLE, `rr_ptr` = 0.
- Reset mid-ACCESS or mid-RESP aborts the transaction in the next cycle: strobes drop and no response is produced.
- Aligned read accepted at edge 0:
  - `mem_rd_en` high in cycles 1..RD_LAT.
  - `rsp_valid` in cycle RD_LAT+1.
  - Next acceptance is possible at the edge ending cycle RD_LAT+2.
  - Aligned writes are analogous with WR_LAT.
- Misaligned: accept at edge 0, `rsp_valid` and `rsp_err` in cycle 1.
- Sustained throughput: one transaction per LAT+2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous requests from all ports, grants rotate strictly, so a port waits at most NUM_PORTS−1 transactions.
- `NUM_PORTS=1`: the arbiter degenerates to a pass-through and `rr_ptr` stays 0.

## Structure
- Package `mem_ctrl_pkg`: state encoding (IDLE, ACCESS, RESP) and a `clog2` function for `OFF` and the counter width.
- Sub-module `rr_arbiter`, parameter `N`:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: one-hot `grant[N]` and `grant_idx`.
  - Combinational priority rotate.
- The top level holds the FSM, latency counter, latch registers and address shifter.

## Test plan
- Read, default parameters: port 0 reads 0x0000_0010 with `mem_rdata`=0xDEAD_BEEF.
  - `mem_addr` = 0x4 and `mem_rd_en` high for cycles 1–2.
  - `rsp_valid` = 2'b01, `rsp_rdata` = 0xDEADBEEF, err 0 in cycle 3.
- Write: port 1 writes 0xCAFE_F00D to 0x20.
  - `mem_wr_en` high for 2 cycles with `mem_addr` = 0x8 and `mem_wdata` = 0xCAFEF00D.
  - `rsp_valid` = 2'b10, `rsp_rdata` = 0.
- Misaligned: port 0 reads 0x13.
  - No `mem_rd_en`; `rsp_valid` = 2'b01 with `rsp_err` = 1 in cycle 1.
- Contention: both ports request continuously for 4 transactions.
  - Grant order 0,1,0,1.
  - Each `req_ready` is one cycle, and only in IDLE.
- Reset abort: assert `reset` during the second ACCESS cycle of a read.
  - Strobes low the next cycle, no `rsp_valid`, `rr_ptr` = 0.
  - A subsequent read from port 1 completes normally.
- Parameter sweep: `DATA_W=64`, `RD_LAT=4`, `NUM_PORTS=3`.
  - Address 0x40 -> `mem_addr` 0x8.
  - `rsp_valid` arrives in cycle 5.
  - Address 0x44 is flagged misaligned.
